alu_nibble_sequencer: RTL and testbench

Multi-nibble command front end for the registered 4-bit ALU (`alu_4bit`). It accepts a wide operation over a valid/ready command channel and slices it into 4-bit nibbles. It drives each nibble into the ALU and collects the ALU's registered results, chaining carries for arithmetic. It then returns the assembled wide result over a valid/ready response channel. It sits between a controller and the ALU, acting as the ALU's initiator.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_nibble_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-nibble ALU sequencer.
// Holds the command opcodes, the sequencer state encoding and the ALU opcodes/latency.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT = 3'd0,
        OP_AND = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_e;

    localparam logic [2:0] ALU_OP_NOT = 3'd0;
    localparam logic [2:0] ALU_OP_AND = 3'd1;
    localparam logic [2:0] ALU_OP_XOR = 3'd2;
    localparam logic [2:0] ALU_OP_ADD = 3'd3;

    // Cycles from driving alu_* inputs to the result being visible on alu_* outputs.
    localparam int ALU_LAT = 2;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Slices a wide command into 4-bit nibbles for the registered alu_4bit and reassembles the result.
// Define ALU_SEQ_SUB_EN to enable op 4 (SUB, computed as A + ~B + 1).
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | driving nibbles into the ALU (every cycle for logic, every 2nd for ADD/SUB)
// ST_DRAIN | all nibbles issued, waiting for the last result capture
// ST_RESP  | response held on rsp_* until rsp_ready
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [4*NIBBLES-1:0]   cmd_a,
    input  logic [4*NIBBLES-1:0]   cmd_b,
    input  logic                   cmd_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_data,
    output logic                   rsp_cout,
    output logic                   rsp_err,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_c,
    output logic [2:0]             alu_opcode,
    input  logic [3:0]             alu_not,
    input  logic [3:0]             alu_and,
    input  logic [3:0]             alu_xor,
    input  logic [3:0]             alu_sum,
    input  logic                   alu_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    seq_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [ALU_LAT-1:0] pend_v_q, pend_v_d;
    logic [CNT_W-1:0] pend_idx_q [ALU_LAT];
    logic [CNT_W-1:0] pend_idx_d [ALU_LAT];
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_err_q, rsp_err_d;

    logic             is_arith;
    logic             is_sub;
    logic             cmd_legal;
    logic             issue;
    logic             cap;
    logic [CNT_W-1:0] cap_idx;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;

    always_comb begin
        is_sub = 1'b0;
`ifdef ALU_SEQ_SUB_EN
        is_sub = (op_q == OP_SUB);
`endif
        is_arith = (op_q == OP_ADD) || is_sub;

        cmd_legal = 1'b0;
        case (cmd_op)
            OP_NOT, OP_AND, OP_XOR, OP_ADD: cmd_legal = 1'b1;
`ifdef ALU_SEQ_SUB_EN
            OP_SUB:                         cmd_legal = 1'b1;
`endif
            default:                        cmd_legal = 1'b0;
        endcase
    end

    assign issue   = (state_q == ST_ISSUE) && (!is_arith || !phase_q);
    assign cap     = pend_v_q[ALU_LAT-1];
    assign cap_idx = pend_idx_q[ALU_LAT-1];
    assign nib_a   = a_q[{cnt_q, 2'b00} +: 4];
`ifdef ALU_SEQ_SUB_EN
    assign nib_b   = is_sub ? ~b_q[{cnt_q, 2'b00} +: 4] : b_q[{cnt_q, 2'b00} +: 4];
`else
    assign nib_b   = b_q[{cnt_q, 2'b00} +: 4];
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        rsp_data_d = rsp_data_q;
        rsp_cout_d = rsp_cout_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_a      = 4'd0;
        alu_b      = 4'd0;
        alu_c      = 1'b0;
        alu_opcode = 3'd0;

        // Track which nibble each in-flight ALU result belongs to.
        pend_v_d[0]   = issue;
        pend_idx_d[0] = cnt_q;
        for (int i = 1; i < ALU_LAT; i++) begin
            pend_v_d[i]   = pend_v_q[i-1];
            pend_idx_d[i] = pend_idx_q[i-1];
        end

        if (issue) begin
            alu_a = nib_a;
            alu_b = nib_b;
            if (is_arith) begin
                alu_opcode = ALU_OP_ADD;
                // Nibble i>0 chains the carry of nibble i-1, which lands on alu_cout this very cycle.
                if (cnt_q == '0) alu_c = is_sub ? 1'b1 : cin_q;
                else             alu_c = alu_cout;
            end else begin
                case (op_q)
                    OP_AND:  alu_opcode = ALU_OP_AND;
                    OP_XOR:  alu_opcode = ALU_OP_XOR;
                    default: alu_opcode = ALU_OP_NOT;
                endcase
            end
        end

        if (cap) begin
            case (op_q)
                OP_NOT:  rsp_data_d[{cap_idx, 2'b00} +: 4] = alu_not;
                OP_AND:  rsp_data_d[{cap_idx, 2'b00} +: 4] = alu_and;
                OP_XOR:  rsp_data_d[{cap_idx, 2'b00} +: 4] = alu_xor;
                default: rsp_data_d[{cap_idx, 2'b00} +: 4] = alu_sum;
            endcase
            if (is_arith && cap_idx == LAST) rsp_cout_d = alu_cout;
        end

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    cin_d      = cmd_cin;
                    cnt_d      = '0;
                    phase_d    = 1'b0;
                    rsp_data_d = '0;
                    rsp_cout_d = 1'b0;
                    rsp_err_d  = !cmd_legal;
                    state_d    = cmd_legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                if (is_arith) phase_d = !phase_q;
                if (issue) begin
                    if (cnt_q == LAST) state_d = ST_DRAIN;
                    else               cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cap && cap_idx == LAST) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    phase_d    = 1'b0;
                    rsp_data_d = '0;
                    rsp_cout_d = 1'b0;
                    rsp_err_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            pend_v_q   <= '0;
            for (int i = 0; i < ALU_LAT; i++) pend_idx_q[i] <= '0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pend_v_q   <= pend_v_d;
            for (int i = 0; i < ALU_LAT; i++) pend_idx_q[i] <= pend_idx_d[i];
            rsp_data_q <= rsp_data_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_cout = rsp_cout_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural two-stage registered 4-bit ALU.
// Expectations follow ALU_SEQ_SUB_EN when it is defined for the build.
module tb_alu_nibble_sequencer;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic          cmd_cin;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_cout;
    logic          rsp_err;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic          alu_c;
    logic [2:0]    alu_opcode;
    logic [3:0]    alu_not = '0;
    logic [3:0]    alu_and = '0;
    logic [3:0]    alu_xor = '0;
    logic [3:0]    alu_sum = '0;
    logic          alu_cout = 1'b0;

    logic [3:0]    s1_a = '0;
    logic [3:0]    s1_b = '0;
    logic          s1_c = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_opcode (alu_opcode),
        .alu_not    (alu_not),
        .alu_and    (alu_and),
        .alu_xor    (alu_xor),
        .alu_sum    (alu_sum),
        .alu_cout   (alu_cout)
    );

    // Registered ALU: inputs captured, then results registered one cycle later.
    always @(posedge clk) begin
        s1_a <= alu_a;
        s1_b <= alu_b;
        s1_c <= alu_c;
        alu_not <= ~s1_a;
        alu_and <= s1_a & s1_b;
        alu_xor <= s1_a ^ s1_b;
        {alu_cout, alu_sum} <= {1'b0, s1_a} + {1'b0, s1_b} + {4'b0, s1_c};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_cin   = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int lat);
        lat = start;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        check_val({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_data,
                         input logic exp_cout, input logic exp_err, input int exp_lat);
        int lat;
        check_val({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
        send(op, a, b, cin);
        check_val({tag, "_busy"}, 32'(cmd_ready), 32'd0);
        wait_rsp(1, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check_val({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        check_val({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        finish_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp done");
        $fatal(1);
    end

    initial begin
        int lat;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_rsp", {rsp_valid, rsp_cout, rsp_err, 13'd0, rsp_data}, 32'd0);
        check_val("rst_alu", {alu_a, alu_b, alu_c, alu_opcode}, 32'd0);
        rst = 1'b0;
        tick();

        // ADD with full carry ripple; also look at the issue cycles directly.
        send(3'd3, 16'hFFFF, 16'h0001, 1'b0);
        check_val("add1_c1_drive", {alu_opcode, alu_a, alu_b, alu_c}, {3'd3, 4'hF, 4'h1, 1'b0});
        tick();
        check_val("add1_c2_idle", {alu_opcode, alu_a, alu_b, alu_c}, 32'd0);
        tick();
        check_val("add1_c3_chain", {alu_opcode, alu_a, alu_b, alu_c}, {3'd3, 4'hF, 4'h0, 1'b1});
        wait_rsp(3, lat);
        check_val("add1_lat", 32'(lat), 32'd10);
        check_val("add1_data", 32'(rsp_data), 32'h0000);
        check_val("add1_cout", 32'(rsp_cout), 32'd1);
        check_val("add1_err", 32'(rsp_err), 32'd0);
        finish_rsp("add1");

        do_op("xor", 3'd2, 16'hA5A5, 16'h0FF0, 1'b0, 16'hAA55, 1'b0, 1'b0, 7);
        do_op("not", 3'd0, 16'h1234, 16'h0000, 1'b0, 16'hEDCB, 1'b0, 1'b0, 7);
        do_op("and", 3'd1, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 7);
        do_op("add_cin", 3'd3, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0, 10);

        // Backpressure: response held with no ALU activity.
        send(3'd3, 16'h1234, 16'h4321, 1'b0);
        wait_rsp(1, lat);
        check_val("hold_lat", 32'(lat), 32'd10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("hold_data", 32'(rsp_data), 32'h5555);
            check_val("hold_valid", 32'(rsp_valid), 32'd1);
            check_val("hold_ready", 32'(cmd_ready), 32'd0);
            check_val("hold_alu", {alu_a, alu_b, alu_c, alu_opcode}, 32'd0);
        end
        finish_rsp("hold");

        // Reset at cycle 4 of an ADD.
        send(3'd3, 16'h1111, 16'h2222, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_val("mid_rst_rsp", {rsp_valid, rsp_cout, rsp_err, 13'd0, rsp_data}, 32'd0);
        check_val("mid_rst_alu", {alu_a, alu_b, alu_c, alu_opcode}, 32'd0);
        do_op("post_rst", 3'd3, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 10);

`ifdef ALU_SEQ_SUB_EN
        do_op("sub", 3'd4, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 10);
        do_op("sub_nb", 3'd4, 16'h0009, 16'h0004, 1'b0, 16'h0005, 1'b1, 1'b0, 10);
`else
        do_op("sub_off", 3'd4, 16'h0005, 16'h0007, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
`endif

        // Illegal opcode: immediate error response, ALU untouched.
        send(3'd7, 16'hFFFF, 16'hFFFF, 1'b1);
        check_val("ill_valid", 32'(rsp_valid), 32'd1);
        check_val("ill_err", 32'(rsp_err), 32'd1);
        check_val("ill_data", {15'd0, rsp_cout, rsp_data}, 32'd0);
        check_val("ill_alu", {alu_a, alu_b, alu_c, alu_opcode}, 32'd0);
        finish_rsp("ill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
